// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite register bank: byte-writable control registers with write pulses,
// read-only status registers with read pulses for clear-on-read logic.
module axil_ctrl_regs #(
  parameter int NUM_CTRL_REGS   = 8,
  parameter int NUM_STATUS_REGS = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [31:0]                     s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [31:0]                     s_axil_wdata,
  input  logic [3:0]                      s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [31:0]                     s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [31:0]                     s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [NUM_CTRL_REGS*32-1:0]     ctrl_regs,
  output logic [NUM_CTRL_REGS-1:0]        ctrl_wr_pulse,
  input  logic [NUM_STATUS_REGS*32-1:0]   status_regs,
  output logic [NUM_STATUS_REGS-1:0]      status_rd_pulse
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [29:0] CTRL_END    = 30'(NUM_CTRL_REGS);
  localparam logic [29:0] TOT_END     = 30'(NUM_CTRL_REGS + NUM_STATUS_REGS);

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  logic [NUM_CTRL_REGS-1:0][31:0]   ctrl_q;
  logic [NUM_STATUS_REGS-1:0][31:0] status_w;
  logic                             up;
  logic                             aw_held, w_held;
  logic [29:0]                      aw_idx;
  logic [31:0]                      w_data;
  logic [3:0]                       w_strb;
  logic                             commit;
  logic [NUM_CTRL_REGS-1:0]         wr_sel;
  logic [29:0]                      ar_idx;
  logic                             ar_hs;
  logic [31:0]                      rd_data_nxt;
  logic [NUM_STATUS_REGS-1:0]       rd_pulse_nxt;
  rd_state_t                        state, state_nxt;
  logic                             unused;

  assign unused    = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};
  assign ctrl_regs = ctrl_q;
  assign status_w  = status_regs;

  function automatic logic [1:0] dec_resp(input logic [29:0] idx, input logic is_wr);
    if (idx < CTRL_END)     return RESP_OKAY;
    else if (idx < TOT_END) return is_wr ? RESP_SLVERR : RESP_OKAY;
    else                    return RESP_DECERR;
  endfunction

  // Registered "out of reset" flag keeps the ready outputs low during reset
  // without a combinational path from aresetn.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) up <= 1'b0;
    else          up <= 1'b1;

  // ---------------- write path ----------------
  assign s_axil_awready = up & ~aw_held;
  assign s_axil_wready  = up & ~w_held;
  assign commit         = aw_held & w_held & ~s_axil_bvalid;

  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NUM_CTRL_REGS; k++)
      wr_sel[k] = commit && (aw_idx == 30'(k));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      ctrl_q        <= '0;
      ctrl_wr_pulse <= '0;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axil_awaddr[31:2];
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end else if (commit) begin
        w_held <= 1'b0;
      end
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= dec_resp(aw_idx, 1'b1);
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      for (int k = 0; k < NUM_CTRL_REGS; k++)
        for (int b = 0; b < 4; b++)
          if (wr_sel[k] && w_strb[b]) ctrl_q[k][b*8 +: 8] <= w_data[b*8 +: 8];
      ctrl_wr_pulse <= wr_sel;
    end
  end

  // ---------------- read path ----------------
  assign ar_idx = s_axil_araddr[31:2];
  assign ar_hs  = s_axil_arvalid & s_axil_arready;

  always_comb begin
    rd_data_nxt  = '0;
    rd_pulse_nxt = '0;
    for (int k = 0; k < NUM_CTRL_REGS; k++)
      if (ar_idx == 30'(k)) rd_data_nxt = ctrl_q[k];
    for (int j = 0; j < NUM_STATUS_REGS; j++)
      if (ar_idx == 30'(NUM_CTRL_REGS + j)) begin
        rd_data_nxt     = status_w[j];
        rd_pulse_nxt[j] = 1'b1;
      end
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= R_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt      = state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    case (state)
      R_IDLE: begin
        s_axil_arready = up;
        if (s_axil_arvalid && up) state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  // Data is captured at the AR handshake, so it stays stable while rready is low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axil_rdata    <= '0;
      s_axil_rresp    <= RESP_OKAY;
      status_rd_pulse <= '0;
    end else if (ar_hs) begin
      s_axil_rdata    <= rd_data_nxt;
      s_axil_rresp    <= dec_resp(ar_idx, 1'b0);
      status_rd_pulse <= rd_pulse_nxt;
    end else begin
      status_rd_pulse <= '0;
    end
  end

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs: vector table for single accesses plus
// hand-written sequences for decoupled channels, back-pressure and reset.
module tb_axil_ctrl_regs;
  localparam int NC = 8;
  localparam int NS = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [NC*32-1:0] ctrl_regs;
  logic [NC-1:0]    ctrl_wr_pulse;
  logic [NS*32-1:0] status_regs;
  logic [NS-1:0]    status_rd_pulse;

  int n_chk = 0;
  int n_fail = 0;

  axil_ctrl_regs #(.NUM_CTRL_REGS(NC), .NUM_STATUS_REGS(NS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_regs(status_regs), .status_rd_pulse(status_rd_pulse)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          chk_idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output logic [NC-1:0] pulse, output int lat);
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    lat = 0;
    while (!(awready && wready) && lat < 10) begin @(negedge aclk); lat++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; lat = 1;
    while (!bvalid && lat < 10) begin @(negedge aclk); lat++; end
    resp = bresp; pulse = ctrl_wr_pulse;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                    output logic [NS-1:0] pulse, output int lat);
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    lat = 0;
    while (!arready && lat < 10) begin @(negedge aclk); lat++; end
    @(negedge aclk);
    arvalid = 1'b0; lat = 1;
    while (!rvalid && lat < 10) begin @(negedge aclk); lat++; end
    data = rdata; resp = rresp; pulse = status_rd_pulse;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]       resp;
    logic [31:0]      data;
    logic [7:0]       pulse;
    logic [NC*32-1:0] pre;
    int               lat;

    for (int j = 0; j < NS; j++) status_regs[j*32 +: 32] = 32'hCAFE_0001 + (j << 8);

    //        wr  addr           data           strb  idx exp_data       resp   pulse
    vt[0]  = '{1, 32'h0000_0004, 32'hA5A5_1234, 4'hF, 1, 32'hA5A5_1234, 2'b00, 8'h02};
    vt[1]  = '{1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 32'hFFFF_FFFF, 2'b00, 8'h01};
    vt[2]  = '{1, 32'h0000_0000, 32'h1122_3344, 4'h5, 0, 32'hFF22_FF44, 2'b00, 8'h01};
    vt[3]  = '{1, 32'h0000_001F, 32'hDEAD_BEEF, 4'hF, 7, 32'hDEAD_BEEF, 2'b00, 8'h80};
    vt[4]  = '{1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0, 32'hFF22_FF44, 2'b10, 8'h00};
    vt[5]  = '{1, 32'h0000_0040, 32'h1234_5678, 4'hF, 1, 32'hA5A5_1234, 2'b11, 8'h00};
    vt[6]  = '{1, 32'h0000_003C, 32'h0BAD_0BAD, 4'hF, 7, 32'hDEAD_BEEF, 2'b10, 8'h00};
    vt[7]  = '{0, 32'h0000_0004, 32'h0,         4'h0, 0, 32'hA5A5_1234, 2'b00, 8'h00};
    vt[8]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'hFF22_FF44, 2'b00, 8'h00};
    vt[9]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'hCAFE_0001, 2'b00, 8'h01};
    vt[10] = '{0, 32'h0000_003E, 32'h0,         4'h0, 0, 32'hCAFE_0701, 2'b00, 8'h80};
    vt[11] = '{0, 32'h0000_0040, 32'h0,         4'h0, 0, 32'h0,         2'b11, 8'h00};
    vt[12] = '{0, 32'h0000_001C, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 2'b00, 8'h00};
    vt[13] = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 32'h0,         2'b11, 8'h00};

    // Reset held with random stimulus
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      awvalid = 1'(($urandom)); wvalid = 1'(($urandom)); arvalid = 1'(($urandom));
      bready = 1'(($urandom)); rready = 1'(($urandom));
      awaddr = $urandom & 32'h1F; araddr = $urandom & 32'h3F; wdata = $urandom; wstrb = 4'hF;
    end
    @(negedge aclk);
    chk("rst awready", awready, 0);
    chk("rst wready", wready, 0);
    chk("rst arready", arready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst rdata", rdata, 0);
    chk("rst resp", {bresp, rresp}, 0);
    chk("rst ctrl_regs zero", (ctrl_regs == '0), 1);
    chk("rst pulses", {ctrl_wr_pulse, status_rd_pulse}, 0);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post-rst readies", {awready, wready, arready}, 3'b111);

    // Table-driven single accesses
    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) begin
        pre = ctrl_regs;
        wr(vt[i].addr, vt[i].data, vt[i].strb, resp, pulse, lat);
        chk($sformatf("v%0d bresp", i), resp, vt[i].exp_resp);
        chk($sformatf("v%0d wr_pulse", i), pulse, vt[i].exp_pulse);
        chk($sformatf("v%0d b latency", i), lat, 2);
        chk($sformatf("v%0d ctrl reg", i), ctrl_regs[vt[i].chk_idx*32 +: 32], vt[i].exp_data);
        if (vt[i].exp_resp != 2'b00) chk($sformatf("v%0d regs unchanged", i), (ctrl_regs == pre), 1);
        @(negedge aclk);
        chk($sformatf("v%0d pulse cleared", i), {ctrl_wr_pulse, bvalid}, 0);
        chk($sformatf("v%0d readies back", i), {awready, wready}, 2'b11);
      end else begin
        rd(vt[i].addr, data, resp, pulse, lat);
        chk($sformatf("v%0d rdata", i), data, vt[i].exp_data);
        chk($sformatf("v%0d rresp", i), resp, vt[i].exp_resp);
        chk($sformatf("v%0d rd_pulse", i), pulse, vt[i].exp_pulse);
        chk($sformatf("v%0d r latency", i), lat, 1);
        @(negedge aclk);
        chk($sformatf("v%0d rd pulse cleared", i), {status_rd_pulse, rvalid}, 0);
        chk($sformatf("v%0d arready back", i), arready, 1);
      end
    end

    // Decoupled channels: W first, AW three cycles later, B back-pressured
    @(negedge aclk);
    bready = 0; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    @(negedge aclk);
    wvalid = 0;
    chk("dec wready low", wready, 0);
    chk("dec awready high", awready, 1);
    @(negedge aclk);
    @(negedge aclk);
    awaddr = 32'h8; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    chk("dec no early commit", {bvalid, ctrl_wr_pulse}, 0);
    @(negedge aclk);
    chk("dec bvalid", bvalid, 1);
    chk("dec reg2", ctrl_regs[2*32 +: 32], 32'h0BAD_F00D);
    chk("dec pulse", ctrl_wr_pulse, 8'h04);
    awaddr = 32'hC; wdata = 32'h0000_0055; awvalid = 1; wvalid = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    chk("dec2 accepted held", {awready, wready}, 2'b00);
    chk("dec2 bvalid held", bvalid, 1);
    chk("dec2 pulse off", ctrl_wr_pulse, 0);
    @(negedge aclk);
    chk("dec2 reg3 pending", ctrl_regs[3*32 +: 32], 0);
    chk("dec2 bvalid still", bvalid, 1);
    bready = 1;
    @(negedge aclk);
    chk("dec2 b handshake", bvalid, 0);
    @(negedge aclk);
    chk("dec2 commit bvalid", bvalid, 1);
    chk("dec2 reg3", ctrl_regs[3*32 +: 32], 32'h0000_0055);
    chk("dec2 pulse", ctrl_wr_pulse, 8'h08);
    @(negedge aclk);
    chk("dec2 done", {bvalid, ctrl_wr_pulse}, 0);

    // Status read with rready held low
    araddr = 32'h20; arvalid = 1; rready = 0;
    @(negedge aclk);
    arvalid = 0;
    chk("st rvalid", rvalid, 1);
    chk("st rdata", rdata, 32'hCAFE_0001);
    chk("st rresp", rresp, 2'b00);
    chk("st pulse", status_rd_pulse, 8'h01);
    status_regs[31:0] = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      chk("st rdata stable", rdata, 32'hCAFE_0001);
      chk("st arready low", {arready, rvalid}, 2'b01);
      chk("st pulse once", status_rd_pulse, 0);
    end
    rready = 1;
    @(negedge aclk);
    chk("st released", {rvalid, arready}, 2'b01);
    status_regs[31:0] = 32'hCAFE_0001;

    // Reset with pending B, held AW and read in R_DATA
    awaddr = 32'h14; wdata = 32'h77; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    chk("mid bvalid pending", bvalid, 1);
    araddr = 32'h4; arvalid = 1; rready = 0; awaddr = 32'h10; awvalid = 1;
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    chk("mid in R_DATA", {rvalid, awready}, 2'b10);
    #2 aresetn = 0;
    #1;
    chk("mid rst rvalid", rvalid, 0);
    chk("mid rst bvalid", bvalid, 0);
    chk("mid rst ctrl zero", (ctrl_regs == '0), 1);
    chk("mid rst readies", {awready, wready, arready}, 0);
    wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1; bready = 1; rready = 1;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      chk("post-rst no pulse", {ctrl_wr_pulse, bvalid}, 0);
    end
    wvalid = 0;
    chk("post-rst regs zero", (ctrl_regs == '0), 1);
    awaddr = 32'h10; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    @(negedge aclk);
    chk("post-rst commit pulse", ctrl_wr_pulse, 8'h10);
    chk("post-rst reg4", ctrl_regs[4*32 +: 32], 32'h1357_9BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
